// File: rtl/switch_debounce_pulse.sv
// ---------------------------------------------------------------------------
// switch_debounce_pulse
//
// Front-end conditioner for a mechanical push switch. The raw level is
// brought into the clk domain through a two-flop synchroniser. A stability
// counter then rejects bounce on both press and release. Each accepted press
// produces a one-cycle o_pulse, which is meant to drive a downstream counter
// enable. An optional auto-repeat adds one more pulse every REPEAT_CYCLES
// while the switch stays held.
//
// FSM states:
//   state        | meaning
//   -------------+-----------------------------------------------------------
//   IDLE         | switch released and stable, counter held at 0
//   WAIT_PRESS   | sync high, counting towards STABLE_CYCLES before accepting
//   PRESSED      | press accepted, running the repeat timer (or saturating)
//   WAIT_RELEASE | sync low while pressed, counting towards an accepted release
//
// Parameters:
//   CNT_WIDTH     width of the stability/repeat counter; must hold
//                 max(STABLE_CYCLES, REPEAT_CYCLES)
//   STABLE_CYCLES consecutive synchronised cycles needed to accept (>= 1)
//   REPEAT_CYCLES auto-repeat period in cycles, 0 disables repeat
//
// Ports:
//   clk        system clock, rising edge
//   i_rst      asynchronous active-high reset
//   i_sw       raw switch level, asynchronous to clk, 1 = pressed
//   o_level    debounced switch level (registered)
//   o_pulse    one-cycle press / repeat pulse (registered)
//   o_release  one-cycle pulse on an accepted release (registered)
//   o_state    current FSM state encoding
// ---------------------------------------------------------------------------
module switch_debounce_pulse #(
    parameter int CNT_WIDTH     = 16,
    parameter int STABLE_CYCLES = 4,
    parameter int REPEAT_CYCLES = 0
) (
    input  logic       clk,
    input  logic       i_rst,
    input  logic       i_sw,
    output logic       o_level,
    output logic       o_pulse,
    output logic       o_release,
    output logic [1:0] o_state
);

    typedef enum logic [1:0] {
        IDLE         = 2'b00,
        WAIT_PRESS   = 2'b01,
        PRESSED      = 2'b10,
        WAIT_RELEASE = 2'b11
    } state_t;

    localparam bit                   REPEAT_EN     = (REPEAT_CYCLES != 0);
    localparam int                   REPEAT_LAST_I = (REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0;
    localparam logic [CNT_WIDTH-1:0] STABLE_C      = CNT_WIDTH'(STABLE_CYCLES);
    localparam logic [CNT_WIDTH-1:0] REPEAT_LAST   = CNT_WIDTH'(REPEAT_LAST_I);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX       = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE       = CNT_WIDTH'(1);

    logic                 s1_q;
    logic                 sync_q;
    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 level_q, level_d;
    logic                 pulse_q, pulse_d;
    logic                 release_q, release_d;

    // Two-flop synchroniser; only sync_q is used by the FSM.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            s1_q   <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            s1_q   <= i_sw;
            sync_q <= s1_q;
        end
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            pulse_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            pulse_q   <= pulse_d;
            release_q <= release_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        pulse_d   = 1'b0;
        release_d = 1'b0;

        case (state_q)
            IDLE: begin
                level_d = 1'b0;
                if (sync_q) begin
                    state_d = WAIT_PRESS;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end

            WAIT_PRESS: begin
                if (!sync_q) begin
                    // Glitch shorter than the stability window: drop it.
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_C) begin
                    state_d = PRESSED;
                    pulse_d = 1'b1;
                    level_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end

            PRESSED: begin
                if (!sync_q) begin
                    state_d = WAIT_RELEASE;
                    cnt_d   = CNT_ONE;
                end else if (REPEAT_EN && (cnt_q == REPEAT_LAST)) begin
                    pulse_d = 1'b1;
                    cnt_d   = '0;
                end else if (cnt_q != CNT_MAX) begin
                    // With repeat disabled the counter parks at all-ones.
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end

            WAIT_RELEASE: begin
                if (sync_q) begin
                    // Bounce during release: back to held, repeat timer restarts.
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_C) begin
                    state_d   = IDLE;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d     = cnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    assign o_level   = level_q;
    assign o_pulse   = pulse_q;
    assign o_release = release_q;
    assign o_state   = state_q;

endmodule

// File: tb/tb_switch_debounce_pulse.sv
// ---------------------------------------------------------------------------
// tb_switch_debounce_pulse
//
// Three instances share clk, reset and switch input:
//   dut     STABLE_CYCLES=4, REPEAT_CYCLES=0 (main checks)
//   dut_rep STABLE_CYCLES=4, REPEAT_CYCLES=5 (auto-repeat)
//   dut_s1  STABLE_CYCLES=1, REPEAT_CYCLES=0 (minimum stability window)
// Timing reference: an input applied just after edge E is captured by s1 at
// E+1, reaches sync at E+2, is seen by the FSM at E+3, so a WAIT_PRESS with
// STABLE_CYCLES=N accepts at edge E+N+3.
// ---------------------------------------------------------------------------
module tb_switch_debounce_pulse;

    logic       clk;
    logic       i_rst;
    logic       i_sw;

    logic       o_level, o_pulse, o_release;
    logic [1:0] o_state;
    logic       rep_level, rep_pulse, rep_release;
    logic [1:0] rep_state;
    logic       s1_level, s1_pulse, s1_release;
    logic [1:0] s1_state;

    int total;
    int bad;

    switch_debounce_pulse #(.CNT_WIDTH(16), .STABLE_CYCLES(4), .REPEAT_CYCLES(0)) dut (
        .clk(clk), .i_rst(i_rst), .i_sw(i_sw),
        .o_level(o_level), .o_pulse(o_pulse), .o_release(o_release), .o_state(o_state)
    );

    switch_debounce_pulse #(.CNT_WIDTH(16), .STABLE_CYCLES(4), .REPEAT_CYCLES(5)) dut_rep (
        .clk(clk), .i_rst(i_rst), .i_sw(i_sw),
        .o_level(rep_level), .o_pulse(rep_pulse), .o_release(rep_release), .o_state(rep_state)
    );

    switch_debounce_pulse #(.CNT_WIDTH(16), .STABLE_CYCLES(1), .REPEAT_CYCLES(0)) dut_s1 (
        .clk(clk), .i_rst(i_rst), .i_sw(i_sw),
        .o_level(s1_level), .o_pulse(s1_pulse), .o_release(s1_release), .o_state(s1_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       sw;
        logic       pulse;
        logic       level;
        logic       rel;
        logic [1:0] state;
        logic       pulse_s1;
    } vec_t;

    vec_t tbl [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Drive the switch, let one rising edge pass, sample 1 ns later.
    task automatic step(input logic sw);
        i_sw = sw;
        @(posedge clk);
        #1;
        chk("pulse_release_exclusive", 32'(o_pulse & o_release), 32'd0);
    endtask

    initial begin
        logic [2:0]  cnt3;
        logic [15:0] mask16, mask16_s1;
        logic [20:0] rep_mask;
        logic [11:0] mask12, rel12;
        int          n_pulse, n_rel, n_rep_rel, first_k;
        bit          found;

        total = 0;
        bad   = 0;

        // Clean press followed by a bouncy release (dut, plus dut_s1 pulse).
        //           sw    pulse level rel   state  s1pulse
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0};
        tbl[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0};
        tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0};
        tbl[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};

        // Power-on reset, then 10 idle cycles.
        i_rst = 1'b1;
        i_sw  = 1'b0;
        #12;
        chk("por_outputs", 32'({o_pulse, o_level, o_release, o_state}), 32'd0);
        i_rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step(1'b0);
            chk($sformatf("idle%0d", k), 32'({o_pulse, o_level, o_release, o_state}), 32'd0);
        end

        // Table: clean press, hold, bouncy release.
        for (int i = 0; i < 20; i++) begin
            step(tbl[i].sw);
            chk($sformatf("tbl%0d plrs", i), 32'({o_pulse, o_level, o_release, o_state}),
                32'({tbl[i].pulse, tbl[i].level, tbl[i].rel, tbl[i].state}));
            chk($sformatf("tbl%0d s1_pulse", i), 32'(s1_pulse), 32'(tbl[i].pulse_s1));
        end
        chk("s1_idle_after_tbl", 32'({s1_level, s1_release, s1_state}), 32'd0);

        // Press bounce 1,0,1,0 then steady high: single pulse 6 steps after final rise.
        mask16    = '0;
        mask16_s1 = '0;
        for (int k = 0; k < 16; k++) begin
            step((k < 4) ? ((k % 2) == 0) : 1'b1);
            mask16[k]    = o_pulse;
            mask16_s1[k] = s1_pulse;
        end
        chk("bounce_pulse_mask", 32'(mask16), 32'h0400);
        chk("bounce_pulse_mask_s1", 32'(mask16_s1), 32'h0080);

        // Long hold without repeat: no further pulses.
        n_pulse = 0;
        for (int k = 0; k < 50; k++) begin
            step(1'b1);
            if (o_pulse) n_pulse++;
        end
        chk("hold50_pulses", 32'(n_pulse), 32'd0);
        chk("hold50_level_state", 32'({o_level, o_state}), 32'b1_10);

        // Clean release: exactly one release pulse, no press pulse.
        n_pulse = 0;
        n_rel   = 0;
        for (int k = 0; k < 10; k++) begin
            step(1'b0);
            if (o_pulse)   n_pulse++;
            if (o_release) n_rel++;
        end
        chk("release_count", 32'(n_rel), 32'd1);
        chk("release_no_pulse", 32'(n_pulse), 32'd0);
        chk("release_level_state", 32'({o_level, o_state}), 32'd0);

        // Auto-repeat, model of the downstream 3-bit counter cleared first.
        cnt3    = 3'd0;
        found   = 1'b0;
        first_k = -1;
        for (int k = 0; k < 30 && !found; k++) begin
            step(1'b1);
            if (rep_pulse) begin
                found   = 1'b1;
                first_k = k;
                cnt3    = cnt3 + 3'd1;
            end
        end
        chk("rep_first_pulse_step", 32'(first_k), 32'd6);
        rep_mask = '0;
        for (int k = 1; k <= 20; k++) begin
            step(1'b1);
            rep_mask[k] = rep_pulse;
            if (rep_pulse) cnt3 = cnt3 + 3'd1;
        end
        chk("rep_pulse_spacing", 32'(rep_mask), 32'h108420);
        chk("rep_hold_level_state", 32'({rep_level, rep_state}), 32'b1_10);
        n_rep_rel = 0;
        for (int k = 0; k < 10; k++) begin
            step(1'b0);
            if (rep_pulse) cnt3 = cnt3 + 3'd1;
            if (rep_release) n_rep_rel++;
        end
        chk("rep_counter_value", 32'(cnt3), 32'b101);
        chk("rep_release_count", 32'(n_rep_rel), 32'd1);

        // Asynchronous reset while PRESSED: outputs clear without a clock edge.
        for (int k = 0; k < 8; k++) step(1'b1);
        chk("pre_reset_level", 32'({o_level, o_state}), 32'b1_10);
        #3;
        i_rst = 1'b1;
        #1;
        chk("async_reset_outputs", 32'({o_pulse, o_level, o_release, o_state}), 32'd0);
        i_sw = 1'b0;
        #2;
        i_rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step(1'b0);
            chk($sformatf("post_reset%0d", k), 32'({o_pulse, o_level, o_release, o_state}), 32'd0);
        end

        // Reset in WAIT_PRESS with cnt=2, switch kept high: full restart.
        for (int k = 0; k < 4; k++) step(1'b1);
        chk("wait_press_before_reset", 32'(o_state), 32'b01);
        #3;
        i_rst = 1'b1;
        #1;
        chk("wp_reset_outputs", 32'({o_pulse, o_level, o_release, o_state}), 32'd0);
        #2;
        i_rst  = 1'b0;
        mask12 = '0;
        rel12  = '0;
        for (int k = 0; k < 12; k++) begin
            step(1'b1);
            mask12[k] = o_pulse;
            rel12[k]  = o_release;
        end
        chk("wp_reset_pulse_mask", 32'(mask12), 32'h040);
        chk("wp_reset_no_release", 32'(rel12), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
